// File: rtl/hazard_pkg.sv
// Shared constants and types for the RV32I hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } hz_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one execute-stage source register.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    output logic [1:0]            Forward
);

    logic matchM;
    logic matchW;

    assign matchM = RegWriteM && (RdM != '0) && (RdM == RsE);
    assign matchW = RegWriteW && (RdW != '0) && (RdW == RsE);

    // The memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        Forward = FWD_RF;
        if (matchM) begin
            Forward = FWD_MEM;
        end else if (matchW) begin
            Forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: shadow E/M/W pipeline, stall/flush
// generation, data-memory wait watchdog and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 255,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  PCSrcE,
    input  logic                  mem_req_m,
    input  logic                  mem_ready_m,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  StallW,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [REG_ADDR_W-1:0] Rs1E;
    logic [REG_ADDR_W-1:0] Rs2E;
    logic [REG_ADDR_W-1:0] RdE;
    logic                  RegWriteE;
    logic                  IsLoadE;
    logic [REG_ADDR_W-1:0] RdM;
    logic                  RegWriteM;
    logic [REG_ADDR_W-1:0] RdW;
    logic                  RegWriteW;

    hz_state_t             state;
    logic [WAIT_W-1:0]     waitCnt;
    logic [WAIT_W-1:0]     nextCnt;

    logic isLoadD;
    logic freeze;
    logic lwStall;

    assign isLoadD = (ResultSrcD == RESULTSRC_LOAD);
    assign freeze  = mem_req_m & ~mem_ready_m;
    assign lwStall = IsLoadE & RegWriteE & (RdE != '0) &
                     ((RdE == Rs1D) | (RdE == Rs2D));

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .RsE       (Rs1E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardAE)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .RsE       (Rs2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .Forward   (ForwardBE)
    );

    // A freeze masks load-use and branch effects; they reappear on the first
    // unfrozen cycle because E is still held then. A D flush beats a D stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else begin
            StallF = lwStall;
            StallD = lwStall & ~PCSrcE;
            FlushD = PCSrcE;
            FlushE = lwStall | PCSrcE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            RegWriteE <= 1'b0;
            IsLoadE   <= 1'b0;
            RdM       <= '0;
            RegWriteM <= 1'b0;
            RdW       <= '0;
            RegWriteW <= 1'b0;
        end else if (!freeze) begin
            if (FlushE) begin
                Rs1E      <= '0;
                Rs2E      <= '0;
                RdE       <= '0;
                RegWriteE <= 1'b0;
                IsLoadE   <= 1'b0;
            end else begin
                Rs1E      <= Rs1D;
                Rs2E      <= Rs2D;
                RdE       <= RdD;
                RegWriteE <= RegWriteD;
                IsLoadE   <= isLoadD;
            end
            RdM       <= RdE;
            RegWriteM <= RegWriteE;
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
        end
    end

    assign nextCnt = (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + WAIT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state   <= MEM_WAIT;
                        waitCnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state <= RUN;
                    end else begin
                        waitCnt <= nextCnt;
                        if (nextCnt == WAIT_MAX) begin
                            mem_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((lwStall | freeze) && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (!freeze && PCSrcE && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (small MAX_WAIT and CNT_W).
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int RW = 5;
    localparam int MW = 8;
    localparam int CW = 4;

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100001;
    localparam logic [6:0] C_BR   = 7'b0000011;
    localparam logic [6:0] C_LWBR = 7'b1000011;
    localparam logic [6:0] C_FRZ  = 7'b1111100;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] Rs1D, Rs2D, RdD;
    logic          RegWriteD;
    logic [1:0]    ResultSrcD;
    logic          PCSrcE, mem_req_m, mem_ready_m;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic          mem_timeout;
    logic [CW-1:0] stall_count, flush_count;

    typedef struct {
        string      tag;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [6:0] ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic       to;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_ADDR_W(RW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdD         (RdD),
        .RegWriteD   (RegWriteD),
        .ResultSrcD  (ResultSrcD),
        .PCSrcE      (PCSrcE),
        .mem_req_m   (mem_req_m),
        .mem_ready_m (mem_ready_m),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input string tag, input int rs1, input int rs2, input int rd,
                                 input bit rw, input bit ld, input bit pc, input bit req,
                                 input bit rdy, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [6:0] ctl, input int sc, input int fc, input bit to);
        exp_t e;
        Rs1D        = RW'(rs1);
        Rs2D        = RW'(rs2);
        RdD         = RW'(rd);
        RegWriteD   = rw;
        ResultSrcD  = ld ? RESULTSRC_LOAD : 2'b00;
        PCSrcE      = pc;
        mem_req_m   = req;
        mem_ready_m = rdy;
        e.tag = tag;
        e.fa  = fa;
        e.fb  = fb;
        e.ctl = ctl;
        e.sc  = CW'(sc);
        e.fc  = CW'(fc);
        e.to  = to;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            cmp({e.tag, ".fwdA"}, 32'(ForwardAE), 32'(e.fa));
            cmp({e.tag, ".fwdB"}, 32'(ForwardBE), 32'(e.fb));
            cmp({e.tag, ".ctl"},
                32'({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}), 32'(e.ctl));
            cmp({e.tag, ".stall_count"}, 32'(stall_count), 32'(e.sc));
            cmp({e.tag, ".flush_count"}, 32'(flush_count), 32'(e.fc));
            cmp({e.tag, ".timeout"}, 32'(mem_timeout), 32'(e.to));
        end
    endtask

    task automatic step(input string tag, input int rs1, input int rs2, input int rd,
                        input bit rw, input bit ld, input bit pc, input bit req, input bit rdy,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] ctl,
                        input int sc, input int fc, input bit to);
        applyStimulus(tag, rs1, rs2, rd, rw, ld, pc, req, rdy, fa, fb, ctl, sc, fc, to);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; ResultSrcD = 2'b00;
        PCSrcE = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    task automatic doReset();
        setIdle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        setIdle();
        rst_n = 1'b0;
        @(negedge clk);
        cmp("reset.fwdA", 32'(ForwardAE), 32'(FWD_RF));
        cmp("reset.fwdB", 32'(ForwardBE), 32'(FWD_RF));
        cmp("reset.ctl", 32'({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}), 32'(C_IDLE));
        cmp("reset.counts", 32'({stall_count, flush_count}), 32'd0);
        cmp("reset.timeout", 32'(mem_timeout), 32'd0);
        cmp("reset.state", 32'(dut.state == RUN), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Forwarding: M-stage, W-stage on rs2, M-over-W priority, x0 exclusion
        step("add_x5",    1, 2, 5, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("sub_x5",    5, 3, 6, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("fwd_mem",   1, 5, 8, 1, 0, 0, 0, 0, FWD_MEM, FWD_RF,  C_IDLE, 0, 0, 0);
        step("fwd_wb_b",  1, 0, 7, 1, 0, 0, 0, 0, FWD_RF,  FWD_WB,  C_IDLE, 0, 0, 0);
        step("x7_b",      2, 0, 7, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("use_x7",    7, 7, 9, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("prio_mw",   1, 2, 0, 1, 0, 0, 0, 0, FWD_MEM, FWD_MEM, C_IDLE, 0, 0, 0);
        step("rd_x0",     0, 0, 10, 1, 0, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 0, 0, 0);
        step("x0_in_m",   0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("x0_in_w",   0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);

        // Load-use on rs1 then on rs2
        step("lw_x3",     2, 0, 3, 1, 1, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("lu_stall",  3, 1, 4, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_LW,   0, 0, 0);
        step("lu_held",   3, 1, 4, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 1, 0, 0);
        step("lu_fwd_wb", 0, 0, 0, 0, 0, 0, 0, 0, FWD_WB,  FWD_RF,  C_IDLE, 1, 0, 0);
        step("lw_x11",    1, 0, 11, 1, 1, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 1, 0, 0);
        step("lu2_stall", 2, 11, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF,  C_LW,   1, 0, 0);
        step("lu2_held",  2, 11, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 2, 0, 0);
        step("lu2_fwd",   0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_WB,  C_IDLE, 2, 0, 0);

        // Branch flush, then branch colliding with a load-use stall
        step("branch",    0, 0, 0, 0, 0, 1, 0, 0, FWD_RF,  FWD_RF,  C_BR,   2, 0, 0);
        step("post_br",   0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 2, 1, 0);
        step("lw_x12",    0, 0, 12, 1, 1, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 2, 1, 0);
        step("lu_and_br", 12, 0, 13, 1, 0, 1, 0, 0, FWD_RF, FWD_RF, C_LWBR, 2, 1, 0);
        step("post_lubr", 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 3, 2, 0);

        // Memory freeze with a pending branch; shadow state must hold
        doReset();
        step("f_add_x5",  1, 2, 5, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        step("f_use_x5",  5, 0, 6, 1, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("frz%0d", i), 0, 0, 0, 0, 0, 1, 1, 0,
                 FWD_MEM, FWD_RF, C_FRZ, i, 0, 0);
        end
        step("frz_ready", 0, 0, 0, 0, 0, 1, 1, 1, FWD_MEM, FWD_RF,  C_BR,   4, 0, 0);
        step("frz_after", 0, 0, 0, 0, 0, 0, 0, 0, FWD_RF,  FWD_RF,  C_IDLE, 4, 1, 0);

        // Watchdog timeout and stall counter saturation
        doReset();
        for (int i = 0; i < 9; i++) begin
            step($sformatf("wait%0d", i), 0, 0, 0, 0, 0, 0, 1, 0,
                 FWD_RF, FWD_RF, C_FRZ, i, 0, 0);
        end
        step("to_release", 0, 0, 0, 0, 0, 0, 1, 1, FWD_RF, FWD_RF,  C_IDLE, 9, 0, 1);
        step("to_sticky",  0, 0, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 9, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sat%0d", i), 0, 0, 0, 0, 0, 0, 1, 0,
                 FWD_RF, FWD_RF, C_FRZ, ((9 + i) > 15) ? 15 : (9 + i), 0, 1);
        end
        step("sat_hold",   0, 0, 0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF,  C_IDLE, 15, 0, 1);

        // Reset asserted in the middle of a memory wait
        mem_req_m   = 1'b1;
        mem_ready_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("pre_rst.state", 32'(dut.state == MEM_WAIT), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("mid_rst.state", 32'(dut.state == RUN), 32'd1);
        cmp("mid_rst.waitcnt", 32'(dut.waitCnt), 32'd0);
        cmp("mid_rst.stall_count", 32'(stall_count), 32'd0);
        cmp("mid_rst.flush_count", 32'(flush_count), 32'd0);
        cmp("mid_rst.timeout", 32'(mem_timeout), 32'd0);
        cmp("mid_rst.ctl", 32'({StallF, StallD, StallE, StallM, StallW, FlushD, FlushE}), 32'(C_FRZ));
        @(posedge clk);
        #1;
        setIdle();
        rst_n = 1'b1;
        @(negedge clk);
        cmp("leftover_expectations", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
